dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//   Shares the single-port data memory between the core load/store port (port 0)
//   and the test/loader port (port 1). Serialises accesses through an
//   IDLE/ISSUE/WAIT FSM, with a wait counter so port 1 cannot starve.
//   A core request that is not yet granted acts as the core's memory stall.
// PARAMETERS
//   ADDR_WIDTH   32  address width, all ports
//   DATA_WIDTH   32  data width, all ports; byte enables are DATA_WIDTH/8 bits
//   MEM_LATENCY  1   cycles from mem_en (read) to valid mem_rdata; legal 1..4
//   MAX_WAIT     4   arbitrations port 1 may lose before forced win; legal >=1
// PORTS
//   clk        in   1    clock, rising edge
//   reset      in   1    asynchronous, active-high
//   cN_req     in   1    N=0,1: request valid; cmd held stable until cN_gnt
//   cN_we      in   1    1=write, 0=read
//   cN_addr    in   AW   byte address
//   cN_wdata   in   DW   write data
//   cN_be      in   DW/8 byte enables
//   cN_gnt     out  1    1-cycle pulse: command issued to memory this cycle
//   cN_rvalid  out  1    1-cycle pulse: cN_rdata valid (reads only)
//   cN_rdata   out  DW   read data, = mem_rdata while cN_rvalid, else 0
//   mem_en     out  1    memory access strobe
//   mem_we     out  1    memory write enable
//   mem_addr   out  AW   memory address
//   mem_wdata  out  DW   memory write data
//   mem_be     out  DW/8 memory byte enables
//   mem_rdata  in   DW   memory read data
// BEHAVIOUR
//   - Reset: state=IDLE, wait_cnt=0, latched cmd=0; every output 0.
//   - IDLE: if any req, pick winner, latch its we/addr/wdata/be -> ISSUE.
//     No req -> stay IDLE. Requests sampled only in IDLE.
//   - Winner: port 0 unless (c1_req & wait_cnt==MAX_WAIT) or only c1_req.
//     Port 1 loses while both req -> wait_cnt++ (saturates at MAX_WAIT).
//     Port 1 wins -> wait_cnt=0. Port 1 idle: wait_cnt holds.
//   - ISSUE (1 cycle): mem_en=1, mem_we/addr/wdata/be = latched cmd,
//     gnt of winner=1. Write -> IDLE. Read -> WAIT, lat_cnt=1.
//   - mem_* outputs are 0 outside ISSUE.
//   - WAIT: lat_cnt++ each cycle. On the cycle lat_cnt==MEM_LATENCY:
//     winner rvalid=1, rdata=mem_rdata, -> IDLE.
//   - Timing, req first seen in IDLE at cycle T: gnt/mem_en at T+1;
//     read rvalid at T+1+MEM_LATENCY; next arbitration at T+2 (write) or
//     T+2+MEM_LATENCY (read).
//   - Requester drops or changes req on the edge after seeing gnt.
//     A req still high in the IDLE cycle after gnt counts as a new request.
//   - At most one gnt and one rvalid asserted in any cycle; never both ports.
//   - Reset mid-operation: in-flight access abandoned; no rvalid is ever
//     produced for it; wait_cnt cleared.
//   - Writes never produce rvalid. Byte enables pass through unmodified.
//     No alignment checking; an all-zero be still performs the access.
// TESTING
//   1. c0 write addr=100 wdata=25 be=4'hF -> c0_gnt, mem_en, mem_we at T+1 with
//      mem_addr=100, mem_wdata=25; no c0_rvalid; IDLE at T+2.
//   2. MEM_LATENCY=2, c0 read addr=96, model returns 32'hDEADBEEF ->
//      c0_rvalid exactly 2 cycles after c0_gnt, c0_rdata=32'hDEADBEEF, 1 cycle.
//   3. c0 and c1 req same cycle (both writes) -> c0_gnt at T+1;
//      c1_gnt at T+3; wait_cnt=1, then 0 after c1 wins.
//   4. c0 writes back-to-back continuously, c1 write held, MAX_WAIT=4 ->
//      c1 loses 4 arbitrations, wins the 5th, then c0 resumes next arbitration.
//   5. c0 read, reset pulsed during WAIT -> all outputs 0 immediately, no rvalid
//      after release; next c0 read completes normally with correct data.
//   6. c1 writes 96 then 100 back-to-back, no c0 -> gnts 2 cycles apart,
//      mem_addr 96 then 100; check gnt/rvalid one-hot every cycle.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port data memory: core port 0 has priority,
// loader port 1 is forced through after MAX_WAIT lost arbitrations.
module dmem_arbiter #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_LATENCY = 1,
  parameter int MAX_WAIT    = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    c0_req,
  input  logic                    c0_we,
  input  logic [ADDR_WIDTH-1:0]   c0_addr,
  input  logic [DATA_WIDTH-1:0]   c0_wdata,
  input  logic [DATA_WIDTH/8-1:0] c0_be,
  output logic                    c0_gnt,
  output logic                    c0_rvalid,
  output logic [DATA_WIDTH-1:0]   c0_rdata,
  input  logic                    c1_req,
  input  logic                    c1_we,
  input  logic [ADDR_WIDTH-1:0]   c1_addr,
  input  logic [DATA_WIDTH-1:0]   c1_wdata,
  input  logic [DATA_WIDTH/8-1:0] c1_be,
  output logic                    c1_gnt,
  output logic                    c1_rvalid,
  output logic [DATA_WIDTH-1:0]   c1_rdata,
  output logic                    mem_en,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  input  logic [DATA_WIDTH-1:0]   mem_rdata
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;
  localparam int WC_WIDTH = $clog2(MAX_WAIT + 1);
  localparam int LC_WIDTH = 3;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [WC_WIDTH-1:0]   wait_cnt_q, wait_cnt_d;
  logic [LC_WIDTH-1:0]   lat_cnt_q, lat_cnt_d;
  logic                  owner_q, owner_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [BE_WIDTH-1:0]   be_q, be_d;

  logic force_c1;
  logic pick_c1;
  logic issuing;
  logic rd_done;

  // Port 1 wins when it is alone or has already lost MAX_WAIT times in a row.
  assign force_c1 = c1_req && (wait_cnt_q == WC_WIDTH'(MAX_WAIT));
  assign pick_c1  = c1_req && (force_c1 || !c0_req);
  assign issuing  = (state_q == ISSUE);
  assign rd_done  = (state_q == WAIT) && (lat_cnt_q == LC_WIDTH'(MEM_LATENCY));

  always_comb begin
    // NOTE: every _d takes its held value first, so no path through the case leaves one unassigned (no latches).
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    lat_cnt_d  = lat_cnt_q;
    owner_d    = owner_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    case (state_q)
      IDLE: begin
        if (c0_req || c1_req) begin
          owner_d = pick_c1;
          we_d    = pick_c1 ? c1_we    : c0_we;
          addr_d  = pick_c1 ? c1_addr  : c0_addr;
          wdata_d = pick_c1 ? c1_wdata : c0_wdata;
          be_d    = pick_c1 ? c1_be    : c0_be;
          state_d = ISSUE;
          if (pick_c1) begin
            wait_cnt_d = '0;
          end else if (c1_req && (wait_cnt_q != WC_WIDTH'(MAX_WAIT))) begin
            wait_cnt_d = wait_cnt_q + WC_WIDTH'(1);
          end
        end
      end
      ISSUE: begin
        state_d   = we_q ? IDLE : WAIT;
        lat_cnt_d = LC_WIDTH'(1);
      end
      WAIT: begin
        if (rd_done) begin
          state_d = IDLE;
        end else begin
          lat_cnt_d = lat_cnt_q + LC_WIDTH'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      lat_cnt_q  <= '0;
      owner_q    <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      lat_cnt_q  <= lat_cnt_d;
      owner_q    <= owner_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
    end
  end

  // All outputs decode from registered state, so reset clears them immediately.
  assign mem_en    = issuing;
  assign mem_we    = issuing && we_q;
  assign mem_addr  = issuing ? addr_q  : '0;
  assign mem_wdata = issuing ? wdata_q : '0;
  assign mem_be    = issuing ? be_q    : '0;

  assign c0_gnt    = issuing && !owner_q;
  assign c1_gnt    = issuing &&  owner_q;
  assign c0_rvalid = rd_done && !owner_q;
  assign c1_rvalid = rd_done &&  owner_q;
  assign c0_rdata  = c0_rvalid ? mem_rdata : '0;
  assign c1_rdata  = c1_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a latency-pipelined memory model plus grant/read
// scoreboards filled as requests are driven and drained as the DUT answers.
module tb_dmem_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int BW  = DW / 8;
  localparam int LAT = 2;
  localparam int MW  = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          c0_req, c0_we, c1_req, c1_we;
  logic [AW-1:0] c0_addr, c1_addr;
  logic [DW-1:0] c0_wdata, c1_wdata;
  logic [BW-1:0] c0_be, c1_be;
  logic          c0_gnt, c0_rvalid, c1_gnt, c1_rvalid;
  logic [DW-1:0] c0_rdata, c1_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [BW-1:0] mem_be;
  logic [DW-1:0] mem_rdata;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(LAT), .MAX_WAIT(MW)
  ) dut (
    .clk(clk), .reset(reset),
    .c0_req(c0_req), .c0_we(c0_we), .c0_addr(c0_addr), .c0_wdata(c0_wdata), .c0_be(c0_be),
    .c0_gnt(c0_gnt), .c0_rvalid(c0_rvalid), .c0_rdata(c0_rdata),
    .c1_req(c1_req), .c1_we(c1_we), .c1_addr(c1_addr), .c1_wdata(c1_wdata), .c1_be(c1_be),
    .c1_gnt(c1_gnt), .c1_rvalid(c1_rvalid), .c1_rdata(c1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata)
  );

  // Memory model: byte-enabled writes, reads appear LAT cycles after mem_en.
  logic [DW-1:0] mem_model [256];
  logic [DW-1:0] shadow    [256];
  logic [DW-1:0] rd_pipe   [LAT];

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                          input logic [BW-1:0] be);
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < BW; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    if (mem_en && mem_we) mem_model[mem_addr[9:2]] <= merge(mem_model[mem_addr[9:2]], mem_wdata, mem_be);
    rd_pipe[0] <= (mem_en && !mem_we) ? mem_model[mem_addr[9:2]] : '0;
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rdata = rd_pipe[LAT-1];

  typedef struct packed {
    logic          port;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [BW-1:0] be;
  } cmd_t;

  typedef struct packed {
    logic          port;
    logic [DW-1:0] data;
  } rd_t;

  cmd_t gnt_q[$];
  rd_t  rd_q[$];

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Per-cycle monitor: exclusivity, idle-zero outputs, and scoreboard drain.
  always @(negedge clk) begin
    check("gnt_onehot", 160'(c0_gnt & c1_gnt), 160'(0));
    check("rvalid_onehot", 160'(c0_rvalid & c1_rvalid), 160'(0));
    if (c0_gnt || c1_gnt) begin
      if (gnt_q.size() == 0) begin
        check("gnt_unexpected", 160'(1), 160'(0));
      end else begin
        check("gnt_cmd", 160'({c1_gnt, mem_we, mem_addr, mem_wdata, mem_be}), 160'(gnt_q[0]));
        check("gnt_mem_en", 160'(mem_en), 160'(1));
        gnt_q.delete(0);
      end
    end else begin
      check("mem_idle", 160'({mem_en, mem_we, mem_addr, mem_wdata, mem_be}), 160'(0));
    end
    if (c0_rvalid || c1_rvalid) begin
      if (rd_q.size() == 0) begin
        check("rvalid_unexpected", 160'(1), 160'(0));
      end else begin
        check("rvalid_data", 160'({c1_rvalid, c1_rvalid ? c1_rdata : c0_rdata}), 160'(rd_q[0]));
        check("rdata_other_zero", 160'(c1_rvalid ? c0_rdata : c1_rdata), 160'(0));
        rd_q.delete(0);
      end
    end else begin
      check("rdata_idle", 160'({c0_rdata, c1_rdata}), 160'(0));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input bit p, input logic req, input logic we, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [BW-1:0] be);
    if (!p) begin
      c0_req = req; c0_we = we; c0_addr = a; c0_wdata = d; c0_be = be;
    end else begin
      c1_req = req; c1_we = we; c1_addr = a; c1_wdata = d; c1_be = be;
    end
  endtask

  task automatic idle_port(input bit p);
    set_port(p, 1'b0, 1'b0, '0, '0, '0);
  endtask

  // Must be called in the order the bench expects the DUT to issue commands.
  task automatic expect_cmd(input bit p, input logic we, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input logic [BW-1:0] be, input bit want_rd);
    gnt_q.push_back('{port: p, we: we, addr: a, wdata: d, be: be});
    if (we) shadow[a[9:2]] = merge(shadow[a[9:2]], d, be);
    else if (want_rd) rd_q.push_back('{port: p, data: shadow[a[9:2]]});
  endtask

  // Returns the cycle offset of the grant; stops at that cycle's negedge.
  task automatic wait_gnt(input bit p, output int n);
    n = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if ((p ? c1_gnt : c0_gnt) === 1'b1) begin
        n = i;
        break;
      end
      tick();
    end
    if (n < 0) check("gnt_timeout", 160'(0), 160'(1));
  endtask

  task automatic wait_rvalid(input bit p, output int n);
    n = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if ((p ? c1_rvalid : c0_rvalid) === 1'b1) begin
        n = i;
        break;
      end
      tick();
    end
    if (n < 0) check("rvalid_timeout", 160'(0), 160'(1));
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish (total=%0d bad=%0d)", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int         n;
    int         ng;
    int         c0_k;
    int         t_a;
    logic [5:0] order;
    int         gcyc [6];
    bit         seen0, seen1;

    for (int i = 0; i < 256; i++) begin
      mem_model[i] = '0;
      shadow[i]    = '0;
    end
    mem_model[24] = 32'hDEADBEEF;
    shadow[24]    = 32'hDEADBEEF;
    for (int i = 0; i < LAT; i++) rd_pipe[i] = '0;
    reset = 1'b1;
    idle_port(1'b0);
    idle_port(1'b1);

    // Reset state
    @(negedge clk);
    check("rst_outputs", 160'({c0_gnt, c1_gnt, c0_rvalid, c1_rvalid, c0_rdata, c1_rdata,
                               mem_en, mem_we, mem_addr, mem_wdata, mem_be}), 160'(0));
    check("rst_state", 160'({dut.state_q, dut.wait_cnt_q, dut.addr_q}), 160'(0));
    tick();
    reset = 1'b0;

    // 1: single c0 write
    set_port(1'b0, 1'b1, 1'b1, 32'd100, 32'd25, 4'hF);
    expect_cmd(1'b0, 1'b1, 32'd100, 32'd25, 4'hF, 1'b0);
    wait_gnt(1'b0, n);
    check("t1_gnt_lat", 160'(n), 160'(1));
    check("t1_mem", 160'({mem_en, mem_we, mem_addr, mem_wdata}), 160'({1'b1, 1'b1, 32'd100, 32'd25}));
    tick();
    idle_port(1'b0);
    @(negedge clk);
    check("t1_idle", 160'(dut.state_q), 160'(0));
    check("t1_no_rvalid", 160'(c0_rvalid), 160'(0));
    tick();

    // 2: c0 read with two-cycle memory latency
    set_port(1'b0, 1'b1, 1'b0, 32'd96, 32'd0, 4'hF);
    expect_cmd(1'b0, 1'b0, 32'd96, 32'd0, 4'hF, 1'b1);
    wait_gnt(1'b0, n);
    check("t2_gnt_lat", 160'(n), 160'(1));
    tick();
    idle_port(1'b0);
    wait_rvalid(1'b0, n);
    check("t2_rv_dist", 160'(n + 1), 160'(2));
    check("t2_rdata", 160'(c0_rdata), 160'(32'hDEADBEEF));
    tick();
    @(negedge clk);
    check("t2_rv_pulse", 160'(c0_rvalid), 160'(0));
    tick();

    // 3: simultaneous writes, c0 first, c1 two cycles later
    set_port(1'b0, 1'b1, 1'b1, 32'd8, 32'd1, 4'hF);
    set_port(1'b1, 1'b1, 1'b1, 32'd12, 32'd2, 4'hF);
    expect_cmd(1'b0, 1'b1, 32'd8, 32'd1, 4'hF, 1'b0);
    expect_cmd(1'b1, 1'b1, 32'd12, 32'd2, 4'hF, 1'b0);
    wait_gnt(1'b0, n);
    check("t3_c0_gnt", 160'(n), 160'(1));
    check("t3_wait1", 160'(dut.wait_cnt_q), 160'(1));
    tick();
    idle_port(1'b0);
    wait_gnt(1'b1, n);
    check("t3_c1_gnt", 160'(n), 160'(1));
    check("t3_wait0", 160'(dut.wait_cnt_q), 160'(0));
    tick();
    idle_port(1'b1);

    // 4: c0 streams writes, c1 held; c1 forced through on the 5th arbitration
    c0_k = 0;
    ng = 0;
    order = '0;
    for (int k = 0; k < 6; k++) gcyc[k] = 0;
    set_port(1'b0, 1'b1, 1'b1, 32'd300, 32'h1000, 4'hF);
    set_port(1'b1, 1'b1, 1'b1, 32'd200, 32'h2000, 4'hF);
    for (int k = 0; k < 4; k++)
      expect_cmd(1'b0, 1'b1, 32'(300 + 4 * k), 32'(32'h1000 + k), 4'hF, 1'b0);
    expect_cmd(1'b1, 1'b1, 32'd200, 32'h2000, 4'hF, 1'b0);
    expect_cmd(1'b0, 1'b1, 32'd316, 32'h1004, 4'hF, 1'b0);
    for (int i = 0; i < 60 && ng < 6; i++) begin
      @(negedge clk);
      seen0 = c0_gnt;
      seen1 = c1_gnt;
      if (seen0 || seen1) begin
        order[ng] = seen1;
        gcyc[ng]  = cyc;
        ng++;
      end
      tick();
      if (seen1) idle_port(1'b1);
      if (seen0) begin
        c0_k++;
        if (ng < 6) set_port(1'b0, 1'b1, 1'b1, 32'(300 + 4 * c0_k), 32'(32'h1000 + c0_k), 4'hF);
        else idle_port(1'b0);
      end
    end
    idle_port(1'b0);
    idle_port(1'b1);
    check("t4_count", 160'(ng), 160'(6));
    check("t4_order", 160'(order), 160'(6'b010000));
    check("t4_resume_gap", 160'(gcyc[5] - gcyc[4]), 160'(2));
    tick();

    // 5: reset during read wait abandons the read and clears wait_cnt
    set_port(1'b0, 1'b1, 1'b0, 32'd96, 32'd0, 4'hF);
    set_port(1'b1, 1'b1, 1'b1, 32'd400, 32'h33, 4'hF);
    expect_cmd(1'b0, 1'b0, 32'd96, 32'd0, 4'hF, 1'b0);
    wait_gnt(1'b0, n);
    check("t5_gnt_lat", 160'(n), 160'(1));
    check("t5_wait_pre", 160'(dut.wait_cnt_q), 160'(1));
    tick();
    idle_port(1'b0);
    reset = 1'b1;
    #1;
    check("t5_rst_outputs", 160'({c0_gnt, c1_gnt, c0_rvalid, c1_rvalid, c0_rdata, c1_rdata,
                                  mem_en, mem_we, mem_addr, mem_wdata, mem_be}), 160'(0));
    check("t5_rst_state", 160'({dut.state_q, dut.wait_cnt_q}), 160'(0));
    idle_port(1'b1);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t5_no_rvalid", 160'(c0_rvalid | c1_rvalid), 160'(0));
      tick();
    end
    set_port(1'b0, 1'b1, 1'b0, 32'd96, 32'd0, 4'hF);
    expect_cmd(1'b0, 1'b0, 32'd96, 32'd0, 4'hF, 1'b1);
    wait_gnt(1'b0, n);
    check("t5_regnt_lat", 160'(n), 160'(1));
    tick();
    idle_port(1'b0);
    wait_rvalid(1'b0, n);
    check("t5_rv_dist", 160'(n + 1), 160'(2));
    check("t5_rdata", 160'(c0_rdata), 160'(32'hDEADBEEF));
    tick();

    // 6: back-to-back c1 writes, then read back the partially written word
    set_port(1'b1, 1'b1, 1'b1, 32'd96, 32'h11223344, 4'hF);
    expect_cmd(1'b1, 1'b1, 32'd96, 32'h11223344, 4'hF, 1'b0);
    wait_gnt(1'b1, n);
    t_a = cyc;
    check("t6_gnt_a", 160'({n[7:0], mem_addr}), 160'({8'd1, 32'd96}));
    tick();
    set_port(1'b1, 1'b1, 1'b1, 32'd100, 32'hAABBCCDD, 4'b0101);
    expect_cmd(1'b1, 1'b1, 32'd100, 32'hAABBCCDD, 4'b0101, 1'b0);
    wait_gnt(1'b1, n);
    check("t6_gnt_gap", 160'(cyc - t_a), 160'(2));
    check("t6_gnt_b", 160'({mem_addr, mem_be}), 160'({32'd100, 4'b0101}));
    tick();
    set_port(1'b1, 1'b1, 1'b0, 32'd100, 32'd0, 4'hF);
    expect_cmd(1'b1, 1'b0, 32'd100, 32'd0, 4'hF, 1'b1);
    wait_gnt(1'b1, n);
    tick();
    idle_port(1'b1);
    wait_rvalid(1'b1, n);
    check("t6_rdata", 160'(c1_rdata), 160'(32'h00BB00DD));
    tick();

    repeat (4) tick();
    check("gnt_q_empty", 160'(gnt_q.size()), 160'(0));
    check("rd_q_empty", 160'(rd_q.size()), 160'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
